// File: rtl/demux1to4_buf.sv
// demux1to4_buf
// Registered 1-to-4 demultiplexer with one single-entry buffer per channel.
// One word per cycle arrives on a valid/ready stream. A 2-bit select steers
// it into one of four output buffers. Each buffer has its own valid/ready
// handshake and a wrapping delivery counter for debug.
//
// Optional feature macro: DEMUX4_BCAST_EN
//   When defined, the in_bcast port exists. A word taken with in_bcast=1 is
//   loaded into all four channels at once.
//
// Parameters:
//   WIDTH  data width of the input and of each output channel
//   CNT_W  width of each per-channel delivery counter
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block can accept the word this cycle
//   in_data    input word
//   in_sel     destination channel (0..3)
//   in_bcast   deliver to all four channels (DEMUX4_BCAST_EN only)
//   y0..y3     registered channel output data
//   out_valid  bit c = channel c holds a word
//   out_ready  bit c = consumer c takes the word this cycle
//   cnt0..cnt3 words delivered per channel (wrapping)
module demux1to4_buf #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
`ifdef DEMUX4_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [3:0][WIDTH-1:0] y_q;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0]            valid_q;
  logic [3:0]            free;
  logic [3:0]            drain;
  logic [3:0]            load;
  logic                  accept;
  logic                  bcast;

`ifdef DEMUX4_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A channel that is draining this cycle counts as free, so a full channel
  // can be refilled in the same cycle it is emptied. in_ready therefore
  // depends on out_ready but never on in_valid.
  assign free  = ~valid_q | out_ready;
  assign drain = valid_q & out_ready;

  always_comb begin
    in_ready = free[in_sel];
    if (bcast) begin
      in_ready = &free;
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int c = 0; c < 4; c++) begin
      load[c] = accept & (bcast | (in_sel == 2'(c)));
    end
  end

  // Per-channel buffer: a load wins over a drain, so a simultaneous drain and
  // refill keeps the channel valid with the new word. The data register only
  // changes on a load, which keeps it stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (load[c]) begin
          y_q[c]     <= in_data;
          valid_q[c] <= 1'b1;
        end else if (drain[c]) begin
          valid_q[c] <= 1'b0;
        end
        if (drain[c]) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  assign y0        = y_q[0];
  assign y1        = y_q[1];
  assign y2        = y_q[2];
  assign y3        = y_q[3];
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign cnt3      = cnt_q[3];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_demux1to4_buf.sv
// tb_demux1to4_buf
// Directed self-checking bench for demux1to4_buf. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values.
// Compile with DEMUX4_BCAST_EN defined to also exercise broadcast.
module tb_demux1to4_buf;

  localparam int WIDTH = 24;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
`ifdef DEMUX4_BCAST_EN
  logic             in_bcast;
`endif
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

  int checks;
  int failures;

  demux1to4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_sel(in_sel),
`ifdef DEMUX4_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .y0(y0),
    .y1(y1),
    .y2(y2),
    .y3(y3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cnt0(cnt0),
    .cnt1(cnt1),
    .cnt2(cnt2),
    .cnt3(cnt3)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
`ifdef DEMUX4_BCAST_EN
    in_bcast  = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%b want=0000", out_valid);
    end
    checks++;
    if ({y0, y1, y2, y3} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL reset_y got=%h %h %h %h want=0", y0, y1, y2, y3);
    end
    checks++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt got=%0d %0d %0d %0d want=0", cnt0, cnt1, cnt2, cnt3);
    end
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_in_ready sel=%0d got=%b want=1", i, in_ready);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_unicast();
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    in_sel   = 2'd2;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uni_in_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 24'h555555;
    checks++;
    if (y2 !== 24'hABCDEF || out_valid !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL uni_fill got y2=%h vld=%b want y2=abcdef vld=0100", y2, out_valid);
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000 || cnt2 !== 8'd1 || y2 !== 24'hABCDEF) begin
      failures++;
      $display("[TB] FAIL uni_drain got vld=%b cnt2=%0d y2=%h want 0000 1 abcdef", out_valid, cnt2, y2);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    in_data  = 24'h000AAA;
    in_sel   = 2'd1;
    tick();
    in_data  = 24'h000111;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_stall_ready got=%b want=0", in_ready);
    end
    tick();
    checks++;
    if (y1 !== 24'h000AAA || out_valid !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL bp_hold got y1=%h vld=%b want 000aaa 0010", y1, out_valid);
    end
    in_data = 24'h000333;
    in_sel  = 2'd3;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_other_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (y3 !== 24'h000333 || y1 !== 24'h000AAA || out_valid !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL bp_other got y3=%h y1=%h vld=%b want 000333 000aaa 1010", y3, y1, out_valid);
    end
    out_ready = 4'b1010;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000 || cnt1 !== 8'd1 || cnt3 !== 8'd1) begin
      failures++;
      $display("[TB] FAIL bp_drain got vld=%b cnt1=%0d cnt3=%0d want 0000 1 1", out_valid, cnt1, cnt3);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [3];
    words[0] = 24'h000001;
    words[1] = 24'h000002;
    words[2] = 24'h000003;
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = words[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_ready word=%0d got=%b want=1", i, in_ready);
      end
      tick();
      checks++;
      if (y0 !== words[i] || out_valid[0] !== 1'b1 || cnt0 !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL b2b_word%0d got y0=%h vld0=%b cnt0=%0d want %h 1 %0d", i, y0, out_valid[0], cnt0, words[i], i);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (cnt0 !== 8'd3 || out_valid !== 4'b0000 || y0 !== 24'h000003) begin
      failures++;
      $display("[TB] FAIL b2b_final got cnt0=%0d vld=%b y0=%h want 3 0000 000003", cnt0, out_valid, y0);
    end
  endtask

  // cnt3 is 1 on entry. 255 streamed words give 254 drains while streaming
  // (count reaches 255), then the final drain wraps it to 0.
  task automatic test_wrap();
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int i = 0; i < 255; i++) begin
      in_data = 24'(i);
      tick();
    end
    checks++;
    if (cnt3 !== 8'd255 || out_valid[3] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_pre got cnt3=%0d vld3=%b want 255 1", cnt3, out_valid[3]);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (cnt3 !== 8'd0 || out_valid[3] !== 1'b0 || y3 !== 24'd254) begin
      failures++;
      $display("[TB] FAIL wrap_post got cnt3=%0d vld3=%b y3=%h want 0 0 0000fe", cnt3, out_valid[3], y3);
    end
  endtask

  task automatic test_independent();
    in_valid = 1'b1;
    in_data  = 24'h0BEEF1;
    in_sel   = 2'd1;
    tick();
    in_data   = 24'h0CAFE0;
    in_sel    = 2'd0;
    out_ready = 4'b0010;
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0001 || y0 !== 24'h0CAFE0 || y1 !== 24'h0BEEF1 || cnt1 !== 8'd2) begin
      failures++;
      $display("[TB] FAIL indep got vld=%b y0=%h y1=%h cnt1=%0d want 0001 0cafe0 0beef1 2", out_valid, y0, y1, cnt1);
    end
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    checks++;
    if (cnt0 !== 8'd4 || out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL indep_drain got cnt0=%0d vld=%b want 4 0000", cnt0, out_valid);
    end
  endtask

`ifdef DEMUX4_BCAST_EN
  task automatic test_bcast();
    in_valid = 1'b1;
    in_data  = 24'h0000C2;
    in_sel   = 2'd2;
    tick();
    in_bcast = 1'b1;
    in_data  = 24'h123456;
    in_sel   = 2'd0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bcast_stall got=%b want=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0100 || y0 === 24'h123456) begin
      failures++;
      $display("[TB] FAIL bcast_hold got vld=%b y0=%h want 0100 and y0 not 123456", out_valid, y0);
    end
    out_ready = 4'b0100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bcast_release got=%b want=1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b1111 || y0 !== 24'h123456 || y1 !== 24'h123456 ||
        y2 !== 24'h123456 || y3 !== 24'h123456) begin
      failures++;
      $display("[TB] FAIL bcast_load got vld=%b y=%h %h %h %h want 1111 123456", out_valid, y0, y1, y2, y3);
    end
  endtask
`endif

  // Reset asserted while words are buffered clears them at once, without
  // waiting for a clock edge and without counting a drain.
  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 24'h00F00D;
    in_sel   = 2'd0;
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || y0 !== 24'd0 || cnt0 !== 8'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got vld=%b y0=%h cnt0=%0d want 0000 0 0", out_valid, y0, cnt0);
    end
    tick();
    checks++;
    if (cnt0 !== 8'd0 || out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_no_drain got cnt0=%0d vld=%b want 0 0000", cnt0, out_valid);
    end
    out_ready = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_independent();
`ifdef DEMUX4_BCAST_EN
    test_bcast();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1to4_buf.md
# demux1to4_buf

Registered 1-to-4 demultiplexer for the 24-bit datapath. It accepts one word per cycle on a valid/ready input stream and steers it, using a 2-bit select, into one of four single-entry output buffers, each with its own valid/ready handshake. It sits on the producer side of the 4-to-1 operand/result multiplexing, fanning results (e.g. write-back data) out to four consumers. Each output channel also keeps a wrapping delivery counter for debug.

## Interface
Parameters:
- WIDTH, 24, data width of the input and each output channel
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel (0..3)
- in_bcast  input  1  deliver to all four channels (present only with DEMUX4_BCAST_EN)
- y0, y1, y2, y3  output  WIDTH each  channel output data (registered)
- out_valid  output  4  bit c = channel c holds a word
- out_ready  input  4  bit c = consumer c takes the word this cycle
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  words delivered per channel

## Operation
- Each channel c holds one buffer, out_valid[c], and the data register yc.
- Channel c is free when out_valid[c]=0 or out_ready[c]=1. A draining channel counts as free in the same cycle.
- in_ready = free[in_sel]. This is a combinational path from out_ready to in_ready; there is no path from in_valid to in_ready.
- Accept occurs when in_valid & in_ready at a rising edge. On accept: y[in_sel] ← in_data and out_valid[in_sel] ← 1.
- Drain occurs when out_valid[c] & out_ready[c] at an edge. On drain without a new accept to c: out_valid[c] ← 0, and yc holds its last value.
- Simultaneous drain and accept on the same channel: yc takes the new word and out_valid[c] stays 1.
- Accepts to channel a and drains on channels b≠a are fully independent in the same cycle.
- yc must stay stable while out_valid[c] & ~out_ready[c].
- cntc increments by 1 on each drain of channel c and wraps from 2^CNT_W−1 to 0.
- in_sel and in_data are ignored when in_valid=0.
- in_valid=1 with in_ready=0 stalls the input. The producer must hold in_data and in_sel stable while stalled.

## Timing
- Reset: out_valid=4'b0000, y0..y3=0, cnt0..cnt3=0. in_ready then equals 1 for any in_sel.
- Reset takes effect immediately (asynchronous) and is released synchronously to the clock.
- Reset asserted mid-transfer discards all buffered words; no drain is counted.
- Latency: a word accepted at edge N is visible on yc with out_valid[c]=1 after edge N.
- Throughput: one word per cycle, provided the selected channel drains every cycle or rotates among free channels.
- A full channel whose consumer holds out_ready=0 blocks only input words addressed to that channel.

## Configuration
- DEMUX4_BCAST_EN defined:
  - The in_bcast port exists.
  - When in_bcast=1, in_sel is ignored and in_ready = free[0]&free[1]&free[2]&free[3].
  - On accept, all four yc load in_data and all four out_valid bits set.
  - When in_bcast=0, behaviour is unicast as described above.
- DEMUX4_BCAST_EN undefined: the in_bcast port is absent and only unicast exists.

## Test plan
- Reset with out_ready=0000: out_valid=0000, y0..y3=0, cnt*=0, in_ready=1.
- Unicast fill and drain: send 0xABCDEF with sel=2 at edge N. Expect y2=0xABCDEF and out_valid=0100 after N. Hold out_ready[2]=1 for one cycle: out_valid=0000 and cnt2=1.
- Backpressure: channel 1 full, out_ready[1]=0, send 0x000111 with sel=1. Expect in_ready=0 and y1 unchanged. Then send 0x000333 with sel=3: accepted next edge.
- Same-cycle drain and refill on channel 0: stream 0x000001, 0x000002, 0x000003 with out_ready[0]=1. Expect one word per cycle, out_valid[0] continuously 1, cnt0=3 after the final drain.
- Counter wrap with CNT_W=8: perform 256 drains on channel 3. Expect cnt3 to go 255 → 0.
- With DEMUX4_BCAST_EN: channel 2 full and stalled, send in_bcast=1 with 0x123456. Expect in_ready=0. Release out_ready[2]: accepted, all four y = 0x123456, out_valid=1111.
